if_prefetch: RTL

- Parametrised instruction-fetch stage for the MIPS core: PC generation, on-chip instruction memory, and a DEPTH-entry prefetch queue.
- Decouples fetch from decode through a valid/ready handshake.
- Supports redirect (branch/jump/exception) with queue flush and a memory write port for program loading.
- Sits between the PC-select logic and the IF/ID boundary.

---
 rtl/if_prefetch.sv | 96 +++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: PC generation, synchronous instruction memory and a
// first-word fall-through prefetch queue with a valid/ready handshake to decode.
module if_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              IM_AW    = 8,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       WE,
   input  logic [IM_AW-1:0]           W_Addr,
   input  logic [XLEN-1:0]            W_Ins,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_nextpc,
   output logic [XLEN-1:0]            out_ins,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0]             mem [2**IM_AW];
   logic [XLEN-1:0]             fpc, rpc, rdata;
   logic                        rvalid;
   logic [DEPTH-1:0][XLEN-1:0]  q_pc, q_ins;
   logic [PW-1:0]               head, tail;
   logic [CW-1:0]               count;
   logic [CW:0]                 occ;
   logic                        pop, push, issue;

   // Redirect targets are forced word-aligned, so the low bits are dropped.
   logic unused_rpc_lsb;
   assign unused_rpc_lsb = ^redirect_pc[1:0];

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign pop  = (count != '0) && out_ready;
   assign push = rvalid && !RST && !redirect;
   // Occupancy after this edge, counting the read already in flight.
   assign occ   = {1'b0, count} + {{CW{1'b0}}, rvalid} - {{CW{1'b0}}, pop};
   assign issue = !RST && !redirect && !WE && (occ < (CW+1)'(DEPTH));

   always_ff @(posedge CLK) begin
      if (WE)
         mem[W_Addr] <= W_Ins;
      if (issue)
         rdata <= mem[fpc[IM_AW+1:2]];
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         q_pc[tail]  <= rpc;
         q_ins[tail] <= rdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fpc    <= RESET_PC;
         rpc    <= RESET_PC;
         rvalid <= 1'b0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (redirect) begin
         fpc    <= {redirect_pc[XLEN-1:2], 2'b00};
         rvalid <= 1'b0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else begin
         rvalid <= issue;
         if (issue) begin
            rpc <= fpc;
            fpc <= fpc + XLEN'(4);
         end
         if (push) tail <= nxt(tail);
         if (pop)  head <= nxt(head);
         count <= occ[CW-1:0];
      end
   end

   assign out_valid  = (count != '0);
   assign out_pc     = q_pc[head];
   assign out_ins    = q_ins[head];
   assign out_nextpc = q_pc[head] + XLEN'(4);
   assign fifo_count = count;

endmodule
